// File: rtl/ram_burst_reader.sv
// Burst reader for a 1-cycle-latency block-RAM read port.
// Fetches `count` consecutive words starting at `base_addr` and presents them
// as a valid/ready stream. A 2-entry buffer plus read-credit throttling keeps
// every word the RAM returns, whatever the consumer does with m_ready.
module ram_burst_reader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [31:0]      count,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [31:0]      ram_address,
   output logic             ram_oe,
   output logic             ram_we,
   input  logic [WIDTH-1:0] ram_dout,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);

   // The RAM only decodes the low DEPTH bits, so wrap is implicit; the full
   // 32-bit address is still driven. DEPTH only has to be a sane width.
   if (DEPTH < 1 || DEPTH > 32) begin : g_depth_check
      $error("ram_burst_reader: DEPTH must be in 1..32");
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_next;
   logic              done_next;
   logic [31:0]       remaining;
   logic              inflight, inflight_last;
   logic [WIDTH:0]    fifo_mem [2];   // {last, data}
   logic              rd_ptr, wr_ptr;
   logic [1:0]        fifo_count;
   logic              pop, issue, issue_last, accept, kill;
   logic [2:0]        credit;

   assign pop    = m_valid && m_ready;
   assign kill   = abort && (state != IDLE);
   assign accept = (state == IDLE) && start && !abort && (count != 32'd0);
   // Slots that will be occupied at the next edge once this cycle's pop and
   // the word currently coming out of the RAM are accounted for.
   assign credit = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};

   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = fifo_mem[rd_ptr][WIDTH-1:0];
   assign m_last  = m_valid && fifo_mem[rd_ptr][WIDTH];
   assign ram_we  = 1'b0;

   // State register and registered done pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   // Next-state logic; abort beats everything and never produces done
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               if (count == 32'd0) done_next  = 1'b1;
               else                state_next = RUN;
            end
         end
         RUN: begin
            if (abort)                            state_next = IDLE;
            else if (issue && remaining == 32'd1) state_next = DRAIN;
         end
         DRAIN: begin
            if (abort) state_next = IDLE;
            else if (pop && m_last) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs: issue a read only while credit is available
   always_comb begin
      busy       = (state != IDLE);
      issue      = (state == RUN) && (remaining != 32'd0) && (credit < 3'd2);
      issue_last = issue && (remaining == 32'd1);
      ram_oe     = issue;
   end

   // Read address / down-counter and the one-deep in-flight tracker
   always_ff @(posedge clk) begin
      if (!reset) begin
         ram_address   <= 32'd0;
         remaining     <= 32'd0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue && !kill;
         inflight_last <= issue_last;
         if (kill) begin
            remaining <= 32'd0;
         end else if (accept) begin
            ram_address <= base_addr;
            remaining   <= count;
         end else if (issue) begin
            ram_address <= ram_address + 32'd1;
            remaining   <= remaining - 32'd1;
         end
      end
   end

   // Output buffer: RAM data lands one cycle after the read, unconditionally
   always_ff @(posedge clk) begin
      if (!reset) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else if (kill) begin
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_mem[wr_ptr] <= {inflight_last, ram_dout};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: RAM model, scoreboard of expected
// beats computed from base/count, and per-cycle protocol monitors.
module tb_ram_burst_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] count = '0;
   logic        abort = 1'b0;
   logic        busy, done, ram_oe, ram_we, m_valid, m_last;
   logic [31:0] ram_address, m_data;
   logic [31:0] ram_dout = '0;
   logic        m_ready = 1'b0;

   ram_burst_reader #(.WIDTH(32), .DEPTH(10)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .count(count), .abort(abort), .busy(busy), .done(done),
      .ram_address(ram_address), .ram_oe(ram_oe), .ram_we(ram_we),
      .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // RAM model: 1-cycle registered read, mem[k] = k + 100
   logic [31:0] mem [1024];
   initial for (int k = 0; k < 1024; k++) mem[k] = k + 100;
   always @(posedge clk) if (ram_oe) ram_dout <= mem[ram_address[9:0]];

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard state
   logic [31:0] q_data [$];
   logic        q_last [$];
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_count = '0;
   int          issued = 0, popped = 0, done_cnt = 0, done_cyc = -1, first_valid_cyc = -1;
   logic        mon_en = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] hold_data = '0;
   logic        hold_last = 1'b0;

   // Monitor: stream stability, address sequence, credit limit, beat data
   always @(negedge clk) begin
      if (mon_en) begin
         logic pop_n;
         pop_n = m_valid && m_ready;
         if (hold_prev) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", m_data, hold_data);
            chk("hold_last", {31'd0, m_last}, {31'd0, hold_last});
         end
         if (ram_oe) begin
            chk("read_budget", {31'd0, issued < int'(exp_count)}, 32'd1);
            chk("read_addr", ram_address, exp_addr);
            exp_addr = exp_addr + 32'd1;
            issued++;
            chk("credit", {31'd0, (issued - popped - int'(pop_n)) <= 2}, 32'd1);
         end
         if (pop_n) begin
            chk("beat_expected", {31'd0, q_data.size() != 0}, 32'd1);
            if (q_data.size() != 0) begin
               chk("beat_data", m_data, q_data[0]);
               chk("beat_last", {31'd0, m_last}, {31'd0, q_last[0]});
               void'(q_data.pop_front());
               void'(q_last.pop_front());
            end
            popped++;
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            chk("done_not_busy", {31'd0, busy}, 32'd0);
         end
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
         hold_last = m_last;
      end else begin
         hold_prev = 1'b0;
      end
   end

   // mode 0: ready held high, 1: pattern 1,0,0,1,0,1..., 2: random ready
   task automatic run_burst(input logic [31:0] base, input logic [31:0] cnt, input int mode);
      logic [31:0] a;
      logic [5:0]  pat;
      int          c0, n, k, exp_done;
      pat = 6'b101001;
      q_data.delete();
      q_last.delete();
      for (int unsigned i = 0; i < cnt; i++) begin
         a = base + i;
         q_data.push_back(mem[a[9:0]]);
         q_last.push_back(i == cnt - 1);
      end
      exp_addr = base; exp_count = cnt; issued = 0; popped = 0;
      done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
      mon_en = 1'b1;
      start = 1'b1; base_addr = base; count = cnt;
      @(posedge clk); #1;
      start = 1'b0; base_addr = $urandom; count = $urandom;
      c0 = cyc;
      chk("busy_after_start", {31'd0, busy}, {31'd0, cnt != 0});
      n = 0; k = 0;
      while (done_cnt == 0 && n < 400) begin
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = pat[k % 6];
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         k++;
         @(negedge clk); #1;
         if (done_cnt == 0) begin @(posedge clk); #1; end
         n++;
      end
      chk("done_seen", {31'd0, done_cnt != 0}, 32'd1);
      repeat (2) begin @(posedge clk); #1; end
      chk("done_once", done_cnt, 32'd1);
      chk("all_beats", q_data.size(), 32'd0);
      chk("all_reads", issued, cnt);
      chk("idle_after", {31'd0, busy}, 32'd0);
      if (mode == 0) begin
         exp_done = (cnt == 0) ? c0 : c0 + int'(cnt) + 2;
         chk("done_latency", done_cyc, exp_done);
         chk("first_valid_latency", first_valid_cyc, (cnt == 0) ? -1 : c0 + 2);
      end
      mon_en = 1'b0;
   endtask

   initial begin
      // Reset with start held high: must be ignored
      start = 1'b1; base_addr = 32'd7; count = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_oe", {31'd0, ram_oe}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_addr", ram_address, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_data", m_data, 32'd0);
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;

      run_burst(32'd5, 32'd4, 0);      // basic burst, full throughput
      run_burst(32'd5, 32'd4, 1);      // same burst under backpressure
      run_burst(32'd5, 32'd0, 0);      // zero-length burst
      run_burst(32'd1022, 32'd4, 0);   // wrap past the RAM depth

      // Abort two cycles into a stalled burst
      q_data.delete(); q_last.delete();
      exp_addr = 32'd40; exp_count = 32'd10; issued = 0; popped = 0; done_cnt = 0;
      m_ready = 1'b0; mon_en = 1'b1;
      start = 1'b1; base_addr = 32'd40; count = 32'd10;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("pre_abort_valid", {31'd0, m_valid}, 32'd1);
      mon_en = 1'b0; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_valid", {31'd0, m_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", {31'd0, done}, 32'd0);
         chk("abort_no_valid", {31'd0, m_valid}, 32'd0);
      end
      run_burst(32'd0, 32'd2, 0);

      // Abort together with start in IDLE: nothing starts
      abort = 1'b1; start = 1'b1; base_addr = 32'd3; count = 32'd5;
      @(posedge clk); #1; abort = 1'b0; start = 1'b0;
      chk("abort_start_busy", {31'd0, busy}, 32'd0);
      chk("abort_start_done", {31'd0, done}, 32'd0);
      chk("abort_start_oe", {31'd0, ram_oe}, 32'd0);

      // Reset mid-burst with the buffer full
      m_ready = 1'b0;
      start = 1'b1; base_addr = 32'd200; count = 32'd8;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("full_before_reset", {31'd0, m_valid}, 32'd1);
      reset = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_oe", {31'd0, ram_oe}, 32'd0);
      chk("mid_rst_addr", ram_address, 32'd0);
      chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
      chk("mid_rst_last", {31'd0, m_last}, 32'd0);
      chk("mid_rst_data", m_data, 32'd0);
      @(posedge clk); #1;
      chk("rst_start_ignored", {31'd0, busy}, 32'd0);
      reset = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", {31'd0, busy}, 32'd0);

      // Randomized bursts against the scoreboard
      for (int r = 0; r < 10; r++)
         run_burst($urandom, 32'($urandom_range(1, 12)), 2);
      run_burst(32'hFFFF_FFFE, 32'd5, 2);   // 32-bit address wrap

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
